// File: rtl/enable_pattern_gen.sv
// enable_pattern_gen
//   Clocked on/off enable pattern for a downstream counter: on_len cycles
//   high, off_len cycles low, repeated burst_cnt times (0 = until stop).
//   Started and aborted by single-cycle pulses; done pulses on natural end.
//
// Optional feature macro: ENPAT_STATUS_EN adds the burst_idx status port.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle start request
//   stop       in   single-cycle abort request
//   on_len     in   [LEN_W]   enable-high cycles per burst
//   off_len    in   [LEN_W]   enable-low cycles between bursts
//   burst_cnt  in   [BURST_W] number of bursts, 0 = infinite
//   enable     out  registered enable for the counter
//   busy       out  registered, high in ON/OFF
//   done       out  one-cycle pulse on natural completion
//   burst_idx  out  [BURST_W] zero-based burst index (ENPAT_STATUS_EN only)
//
// state | meaning
// IDLE  | waiting for an accepted start; enable=0, busy=0
// ON    | enable high, counting down the on phase
// OFF   | enable low, counting down the gap before the next burst
module enable_pattern_gen #(
  parameter int LEN_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [LEN_W-1:0]   on_len,
  input  logic [LEN_W-1:0]   off_len,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               enable,
  output logic               busy,
  output logic               done
`ifdef ENPAT_STATUS_EN
  ,
  output logic [BURST_W-1:0] burst_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   phase_q, phase_d;
  logic [LEN_W-1:0]   on_q, on_d;
  logic [LEN_W-1:0]   off_q, off_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [BURST_W-1:0] bursts_inc;
  logic               enable_q, busy_q, done_q;
  logic               done_d;

  assign bursts_inc = bursts_q + BURST_W'(1);

  // Phase counter is a down-counter loaded with length-1, so the
  // transition happens on the edge where it is already at zero.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    on_d     = on_q;
    off_d    = off_q;
    bcnt_d   = bcnt_q;
    bursts_d = bursts_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && (on_len != '0)) begin
          state_d  = S_ON;
          on_d     = on_len;
          off_d    = off_len;
          bcnt_d   = burst_cnt;
          phase_d  = on_len - LEN_W'(1);
          bursts_d = '0;
        end
      end
      S_ON: begin
        if (stop) begin
          state_d  = S_IDLE;
          phase_d  = '0;
          bursts_d = '0;
        end else if (phase_q == '0) begin
          if ((bcnt_q != '0) && (bursts_inc == bcnt_q)) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            bursts_d = '0;
          end else if (off_q == '0) begin
            // No gap: the next burst starts straight away, enable stays high.
            bursts_d = bursts_inc;
            phase_d  = on_q - LEN_W'(1);
          end else begin
            state_d  = S_OFF;
            bursts_d = bursts_inc;
            phase_d  = off_q - LEN_W'(1);
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      S_OFF: begin
        if (stop) begin
          state_d  = S_IDLE;
          phase_d  = '0;
          bursts_d = '0;
        end else if (phase_q == '0) begin
          state_d = S_ON;
          phase_d = on_q - LEN_W'(1);
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        phase_d  = '0;
        bursts_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      on_q     <= '0;
      off_q    <= '0;
      bcnt_q   <= '0;
      bursts_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      on_q     <= on_d;
      off_q    <= off_d;
      bcnt_q   <= bcnt_d;
      bursts_q <= bursts_d;
      enable_q <= (state_d == S_ON);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef ENPAT_STATUS_EN
  // Cleared on every return to IDLE, so it reads 0 whenever busy is low.
  assign burst_idx = bursts_q;
`endif

endmodule

// File: tb/tb_enable_pattern_gen.sv
// Self-checking bench for enable_pattern_gen. A behavioural model expands
// each configuration into the expected per-cycle output sequence; a 3-bit
// counter model accumulates enabled cycles. Outputs sampled on negedge.
module tb_enable_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] on_len;
  logic [7:0] off_len;
  logic [3:0] burst_cnt;
  logic       enable;
  logic       busy;
  logic       done;
`ifdef ENPAT_STATUS_EN
  logic [3:0] burst_idx;
`endif

  int tests = 0;
  int fails = 0;
  logic [2:0] count3;

  enable_pattern_gen #(.LEN_W(8), .BURST_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .on_len    (on_len),
    .off_len   (off_len),
    .burst_cnt (burst_cnt),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
`ifdef ENPAT_STATUS_EN
    ,
    .burst_idx (burst_idx)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
`ifdef ENPAT_STATUS_EN
    return {enable, busy, done, burst_idx};
`else
    return {enable, busy, done, 4'd0};
`endif
  endfunction

  function automatic logic [6:0] mk(input logic en, input logic bz,
                                    input logic dn, input int idx);
`ifdef ENPAT_STATUS_EN
    return {en, bz, dn, 4'(idx % 16)};
`else
    return {en, bz, dn, 4'd0};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Caller is at a negedge. Starts a pattern and checks every cycle up to and
  // including the done cycle, then returns still at that negedge so a caller
  // may issue another start in the done cycle. inject_at >= 0 pulses a
  // spurious start with different lengths during that cycle.
  task automatic run_pattern(input int on, input int off, input int bc,
                             input int inject_at, input string name);
    logic [6:0] q[$];
    for (int b = 0; b < bc; b++) begin
      for (int k = 0; k < on; k++) q.push_back(mk(1'b1, 1'b1, 1'b0, b));
      if (b != bc - 1)
        for (int k = 0; k < off; k++) q.push_back(mk(1'b0, 1'b1, 1'b0, b + 1));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 0));

    on_len    = 8'(on);
    off_len   = 8'(off);
    burst_cnt = 4'(bc);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Latched values must not track later input changes.
    on_len    = 8'($urandom_range(1, 9));
    off_len   = 8'($urandom_range(0, 9));
    burst_cnt = 4'($urandom_range(0, 15));
    count3    = '0;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("%s cyc%0d", name, i), 32'(obs()), 32'(q[i]));
      if (enable) count3 = count3 + 3'd1;
      if (i < q.size() - 1) begin
        start = (i == inject_at);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk($sformatf("%s count3", name), 32'(count3), 32'((on * bc) % 8));
  endtask

  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s idle%0d", name, i), 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    on_len = '0;
    off_len = '0;
    burst_cnt = '0;
    count3 = '0;
    #13;
    chk("reset", 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(2, "post_reset");

    // Directed patterns from the test plan.
    run_pattern(3, 2, 2, -1, "p322");
    @(negedge clk);
    check_idle(1, "p322_after");
    run_pattern(2, 0, 3, -1, "p203");
    @(negedge clk);

    // Start during ON with other lengths is ignored.
    run_pattern(4, 1, 2, 1, "inject");
    // Start in the done cycle begins a new pattern at the next edge.
    run_pattern(2, 1, 2, -1, "chain");
    @(negedge clk);
    check_idle(1, "chain_after");

    // on_len = 0 start is ignored.
    on_len = 8'd0; off_len = 8'd2; burst_cnt = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle(3, "zero_on");
    // start + stop together in IDLE: stop wins.
    on_len = 8'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_idle(3, "start_stop");

    // Infinite mode toggling, then stop.
    on_len = 8'd1; off_len = 8'd1; burst_cnt = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("inf cyc%0d", k), 32'(obs()),
          32'(mk(1'((k % 2) == 0), 1'b1, 1'b0, (k + 1) / 2)));
      if (k < 43) @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("inf stop", 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
    @(negedge clk);
    check_idle(3, "inf_after");

    // Stop during an ON phase of a finite pattern.
    on_len = 8'd5; off_len = 8'd2; burst_cnt = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("stop_on pre", 32'(obs()), 32'(mk(1'b1, 1'b1, 1'b0, 0)));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle(4, "stop_on");

    // Asynchronous reset in the middle of ON.
    on_len = 8'd5; off_len = 8'd1; burst_cnt = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid pre", 32'(obs()), 32'(mk(1'b1, 1'b1, 1'b0, 0)));
    #2 rst_n = 1'b0;
    #1 chk("rst_mid async", 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(4, "rst_mid_after");

    // Randomized configurations against the model.
    for (int r = 0; r < 10; r++) begin
      int on, off, bc, inj;
      on  = $urandom_range(1, 6);
      off = $urandom_range(0, 4);
      bc  = $urandom_range(1, 4);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, on - 1) : -1;
      run_pattern(on, off, bc, inj, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check_idle(1, $sformatf("rnd%0d_after", r));
      end
    end
    @(negedge clk);
    check_idle(2, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
